// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
// Holds the frame FSM state encoding and the two prefix byte values.
// Also provides the odd-parity helper used when a frame's stop bit arrives.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  // PS/2 frames carry odd parity over the 8 data bits plus the parity bit.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// ps2_filter: 2-flop synchronizer plus glitch filter for one PS/2 line.
// Latency: 2 sync cycles + FILTER_LEN stable cycles before dout follows.
// Ports: CLK100MHZ/reset (sync, active-high), din async in, dout filtered level (resets to 1).
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      dout       <= 1'b1;
      stable_cnt <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // Count consecutive cycles where the synchronized level disagrees with
      // the filtered one; any agreement restarts the run.
      if (sync2 == dout) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(FILTER_LEN - 1)) begin
        dout       <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 keyboard receiver producing scancodes with E0/F0 prefix flags.
// Ports: CLK100MHZ, reset (sync active-high), PS2_CLK/PS2_DATA async inputs;
// scancode/is_break/is_ext held outputs, scan_valid/parity_err/frame_err pulses, busy.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] scancode,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  logic        clk_filt;
  logic        data_filt;
  logic        clk_filt_q;
  logic        fall;

  ps2_state_t  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [16:0] idle_cnt;
  logic        ext_lat;
  logic        brk_lat;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .din       (PS2_CLK),
    .dout      (clk_filt)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .din       (PS2_DATA),
    .dout      (data_filt)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) clk_filt_q <= 1'b1;
    else       clk_filt_q <= clk_filt;
  end

  assign fall = clk_filt_q & ~clk_filt;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      idle_cnt   <= 17'd0;
      ext_lat    <= 1'b0;
      brk_lat    <= 1'b0;
      scancode   <= 8'h00;
      scan_valid <= 1'b0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fall) begin
        idle_cnt <= 17'd0;
        case (state)
          ST_IDLE: begin
            // A high data level on an edge is not a start bit; ignore it.
            if (!data_filt) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_filt, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_filt;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!data_filt) begin
              frame_err <= 1'b1;
              ext_lat   <= 1'b0;
              brk_lat   <= 1'b0;
            end else if (!parity_ok(shreg, par_bit)) begin
              parity_err <= 1'b1;
              ext_lat    <= 1'b0;
              brk_lat    <= 1'b0;
            end else if (shreg == PREFIX_EXT) begin
              ext_lat <= 1'b1;
            end else if (shreg == PREFIX_BRK) begin
              brk_lat <= 1'b1;
            end else begin
              scancode   <= shreg;
              is_break   <= brk_lat;
              is_ext     <= ext_lat;
              scan_valid <= 1'b1;
              ext_lat    <= 1'b0;
              brk_lat    <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // Abandon a stalled partial frame once the keyboard goes quiet.
        if (idle_cnt == 17'(TIMEOUT_CYC - 1)) begin
          state     <= ST_IDLE;
          idle_cnt  <= 17'd0;
          frame_err <= 1'b1;
          ext_lat   <= 1'b0;
          brk_lat   <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 17'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
module tb_ps2_rx;

  localparam int FILTER_LEN  = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 40;

  logic       CLK100MHZ = 1'b0;
  logic       reset     = 1'b1;
  logic       PS2_CLK   = 1'b1;
  logic       PS2_DATA  = 1'b1;
  logic [7:0] scancode;
  logic       scan_valid;
  logic       is_break;
  logic       is_ext;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  int n_valid = 0;
  int n_perr  = 0;
  int n_ferr  = 0;
  int n_mutex = 0;

  // Reference model state: what the keyboard stream should have produced.
  logic [7:0] exp_code = 8'h00;
  logic       exp_brk  = 1'b0;
  logic       exp_ext  = 1'b0;
  logic       pend_brk = 1'b0;
  logic       pend_ext = 1'b0;
  int         exp_v, exp_p, exp_f;
  int         nv0, np0, nf0;

  always #5 CLK100MHZ = ~CLK100MHZ;

  ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK100MHZ  (CLK100MHZ),
    .reset      (reset),
    .PS2_CLK    (PS2_CLK),
    .PS2_DATA   (PS2_DATA),
    .scancode   (scancode),
    .scan_valid (scan_valid),
    .is_break   (is_break),
    .is_ext     (is_ext),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge CLK100MHZ) begin
    if (scan_valid) n_valid++;
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if ((int'(scan_valid) + int'(parity_err) + int'(frame_err)) > 1) n_mutex++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK100MHZ);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DATA = b;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  // kind: 0 good frame, 1 wrong parity, 2 stop bit low
  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par;
    par = ~^b;
    if (kind == 1) par = ~par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(kind == 2 ? 1'b0 : 1'b1);
    PS2_DATA = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic model_frame(input logic [7:0] b, input int kind);
    exp_v = 0; exp_p = 0; exp_f = 0;
    if (kind == 2) begin
      exp_f = 1; pend_brk = 0; pend_ext = 0;
    end else if (kind == 1) begin
      exp_p = 1; pend_brk = 0; pend_ext = 0;
    end else if (b == 8'hE0) begin
      pend_ext = 1;
    end else if (b == 8'hF0) begin
      pend_brk = 1;
    end else begin
      exp_v = 1; exp_code = b; exp_brk = pend_brk; exp_ext = pend_ext;
      pend_brk = 0; pend_ext = 0;
    end
  endtask

  task automatic snap();
    nv0 = n_valid; np0 = n_perr; nf0 = n_ferr;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid_cnt"}, 32'(n_valid - nv0), 32'(exp_v));
    chk({tag, ".perr_cnt"},  32'(n_perr - np0),  32'(exp_p));
    chk({tag, ".ferr_cnt"},  32'(n_ferr - nf0),  32'(exp_f));
    chk({tag, ".scancode"},  32'(scancode), 32'(exp_code));
    chk({tag, ".is_break"},  32'(is_break), 32'(exp_brk));
    chk({tag, ".is_ext"},    32'(is_ext),   32'(exp_ext));
    chk({tag, ".busy"},      32'(busy),     32'd0);
  endtask

  task automatic frame_step(input string tag, input logic [7:0] b, input int kind);
    snap();
    model_frame(b, kind);
    send_frame(b, kind);
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] rb;
    int         rk;
    int         r;

    // Reset state
    wait_cyc(4);
    chk("rst.scancode", 32'(scancode), 32'h00);
    chk("rst.pulses", 32'({scan_valid, parity_err, frame_err}), 32'd0);
    chk("rst.flags", 32'({is_break, is_ext}), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    reset = 1'b0;
    wait_cyc(20);

    // Directed decode cases
    frame_step("plain_1c", 8'h1C, 0);
    frame_step("brk_f0", 8'hF0, 0);
    frame_step("brk_1c", 8'h1C, 0);
    frame_step("again_1c", 8'h1C, 0);
    frame_step("ext_e0", 8'hE0, 0);
    frame_step("ext_f0", 8'hF0, 0);
    frame_step("ext_75", 8'h75, 0);
    frame_step("perr_1c", 8'h1C, 1);
    frame_step("ferr_29", 8'h29, 2);

    // Timeout: five edges then silence
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    wait_cyc(3);
    chk("tmo.busy_mid", 32'(busy), 32'd1);
    wait_cyc(TIMEOUT_CYC + 10);
    exp_v = 0; exp_p = 0; exp_f = 1; pend_brk = 0; pend_ext = 0;
    check_outputs("tmo");
    frame_step("post_tmo_29", 8'h29, 0);

    // Short glitch on the clock line while idle with data low
    snap();
    PS2_DATA = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    wait_cyc(3);
    PS2_CLK = 1'b1;
    wait_cyc(30);
    exp_v = 0; exp_p = 0; exp_f = 0;
    check_outputs("glitch");
    PS2_DATA = 1'b1;
    wait_cyc(HALF);

    // Prefix pending, then reset in the middle of a frame
    frame_step("pre_rst_f0", 8'hF0, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    snap();
    wait_cyc(HALF);
    exp_code = 8'h00; exp_brk = 0; exp_ext = 0; pend_brk = 0; pend_ext = 0;
    exp_v = 0; exp_p = 0; exp_f = 0;
    check_outputs("midrst");
    frame_step("post_rst_1c", 8'h1C, 0);

    // Randomized frame stream against the model
    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 99);
      rb = (r < 20) ? 8'hE0 : (r < 35) ? 8'hF0 : 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 9);
      rk = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      frame_step($sformatf("rnd%0d", n), rb, rk);
    end

    chk("mutex", 32'(n_mutex), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning consecutive stable cycles needed to accept a PS2_CLK level change.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, meaning idle cycles (1 ms at 100 MHz) after which a partial frame is abandoned.
REQ-003 SHALL have port CLK100MHZ  in  1  system clock; the block uses one clock only.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port PS2_CLK  in  1  asynchronous keyboard clock.
REQ-006 SHALL have port PS2_DATA  in  1  asynchronous keyboard data.
REQ-007 SHALL have port scancode  out  8  last completed non-prefix code, held until the next one.
REQ-008 SHALL have port scan_valid  out  1  one-cycle pulse when scancode, is_break and is_ext update.
REQ-009 SHALL have port is_break  out  1  an F0 prefix preceded the current scancode.
REQ-010 SHALL have port is_ext  out  1  an E0 prefix preceded the current scancode.
REQ-011 SHALL have port parity_err  out  1  one-cycle pulse: frame had even parity.
REQ-012 SHALL have port frame_err  out  1  one-cycle pulse: stop bit 0 or timeout.
REQ-013 SHALL have port busy  out  1  high while the FSM is outside IDLE.

Function
REQ-014 SHALL pass PS2_CLK and PS2_DATA through 2-flop synchronizers; the filtered clock changes only after the synchronized level differs from it for FILTER_LEN consecutive cycles.
REQ-015 SHALL detect a falling edge as filtered clock 1->0 and sample synchronized PS2_DATA on that cycle.
REQ-016 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-017 IDLE: edge with data 0 -> DATA, bit count 0; edge with data 1 -> stay IDLE, no error.
REQ-018 DATA: shift bits LSB first; after the 8th edge -> PARITY.
REQ-019 PARITY: latch bit -> STOP.
REQ-020 STOP: on edge -> IDLE; evaluate in this priority order: stop=0 -> frame_err; else parity of 9 bits even -> parity_err; else accept byte.
REQ-021 Accepted E0 SHALL set the ext latch; F0 SHALL set the brk latch; neither pulses scan_valid.
REQ-022 Any other accepted byte SHALL, on the cycle after the stop edge, load scancode, copy latches to is_break and is_ext, pulse scan_valid, and clear both latches.
REQ-023 parity_err and frame_err SHALL pulse on the cycle after the stop edge and clear both latches.
REQ-024 A 17-bit idle counter SHALL reset on every edge and count in non-IDLE states; reaching TIMEOUT_CYC SHALL force IDLE, pulse frame_err, and clear both latches.
REQ-025 At most one of scan_valid, parity_err, frame_err SHALL be high in any cycle.

Reset
REQ-026 Reset SHALL force IDLE, scancode=0x00, all pulses 0, is_break=0, is_ext=0, busy=0, latches clear, counters 0, and filtered clock=1.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte without producing an error pulse; the next frame SHALL decode normally.

Structure
REQ-028 Package ps2_pkg SHALL hold the FSM state typedef and the constants PREFIX_EXT=8'hE0 and PREFIX_BRK=8'hF0.
REQ-029 Synchronizer and filter SHALL be one sub-module, ps2_filter, instantiated once per input line.
REQ-030 RTL SHALL be 120-400 lines with no latches and no derived clocks.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 -> one scan_valid pulse, scancode=0x1C, is_break=0, is_ext=0.
REQ-032 Frames F0,1C -> exactly one scan_valid, scancode=0x1C, is_break=1; then 0x1C alone -> is_break=0.
REQ-033 Frames E0,F0,75 -> one scan_valid, scancode=0x75, is_ext=1, is_break=1.
REQ-034 Frame 0x1C with parity=1 -> parity_err pulse, no scan_valid, scancode unchanged; frame 0x29 with stop=0 -> frame_err pulse.
REQ-035 Stop after 5 edges, wait TIMEOUT_CYC+10 cycles -> one frame_err, busy=0; then frame 0x29 -> scancode=0x29.
REQ-036 Inject a 3-cycle PS2_CLK low glitch in IDLE -> no FSM change; assert reset mid-frame -> outputs at reset values, then frame 0x1C decodes.
